spi_bus_master: RTL and testbench
=================================

SPI_BUS_MASTER -- requirements
Module: spi_bus_master

Interface
REQ-001 Parameters: ADDR_WIDTH, 32, address bits per frame; DATA_WIDTH, 32, data bits per frame; CLK_DIV, 2, i_spi_clk cycles per SCLK half-period (>=1); TURNAROUND, 1, SCLK periods between address and read data (>=0); GAP_PERIODS, 1, minimum SCLK periods with CS high between frames (>=1).
REQ-002 i_spi_clk  in  1  block clock; all logic is on its rising edge.
REQ-003 rst_n  in  1  reset; asynchronous, active-low.
REQ-004 i_req_valid  in  1  request present.
REQ-005 o_req_ready  out  1  request accepted when valid&&ready.
REQ-006 i_req_write  in  1  1=write frame, 0=read frame.
REQ-007 i_req_cmd  in  7  command byte bits [6:0].
REQ-008 i_req_addr  in  ADDR_WIDTH  target address.
REQ-009 i_req_wdata  in  DATA_WIDTH  write data.
REQ-010 o_rsp_valid  out  1  one-cycle frame-complete pulse.
REQ-011 o_rsp_rdata  out  DATA_WIDTH  read data; updated only by read frames.
REQ-012 o_busy  out  1  high whenever state != IDLE.
REQ-013 o_spi_sclk  out  1  SPI clock, mode 0 (idle low).
REQ-014 o_spi_cs_n  out  1  chip select, active low.
REQ-015 o_spi_mosi  out  1  serial data out, MSB first.
REQ-016 i_spi_miso  in  1  serial data in, MSB first.

Function
REQ-017 o_req_ready SHALL be 1 exactly when state == IDLE; i_req_valid in any other state SHALL have no effect.
REQ-018 On acceptance, cmd, addr, wdata and write SHALL be captured; later input changes SHALL NOT affect the frame in flight.
REQ-019 The command byte SHALL be {i_req_write, i_req_cmd[6:0]}.
REQ-020 Write frame: cmd(8), addr(ADDR_WIDTH), wdata(DATA_WIDTH) on MOSI, for 72 bits by default.
REQ-021 Read frame: cmd(8), addr(ADDR_WIDTH), then TURNAROUND periods with MOSI=0, then DATA_WIDTH periods sampling MISO with MOSI=0.
REQ-022 States: IDLE, CMD_ADDR, WDATA, TURNAROUND, RDATA, HOLD, GAP. Transitions:
- IDLE->CMD_ADDR on accept.
- CMD_ADDR->WDATA (write) or ->TURNAROUND (read; ->RDATA directly if TURNAROUND=0) after 8+ADDR_WIDTH periods.
- WDATA->HOLD after DATA_WIDTH periods.
- TURNAROUND->RDATA after TURNAROUND periods.
- RDATA->HOLD after DATA_WIDTH periods.
- HOLD->GAP after CLK_DIV cycles.
- GAP->IDLE after 2*CLK_DIV*GAP_PERIODS cycles.
REQ-023 Each bit period SHALL be 2*CLK_DIV cycles: CLK_DIV cycles with SCLK=0, then CLK_DIV cycles with SCLK=1.
REQ-024 The cycle after acceptance SHALL drive cs_n=0, sclk=0 and MOSI=first bit. MOSI SHALL change only at the start of a low phase.
REQ-025 MISO SHALL be sampled in the last cycle of each RDATA high phase (SCLK falling edge) and shifted into an LSB-first shift register, so the first sampled bit ends as the MSB.
REQ-026 During HOLD, sclk=0 and cs_n=0. On entry to GAP, cs_n=1 and o_rsp_valid pulses for 1 cycle. For reads, o_rsp_rdata SHALL take the assembled word in that same cycle.
REQ-027 Frame timing with cs_n low:
- Write: 72*2*CLK_DIV + CLK_DIV cycles.
- Read: (40+TURNAROUND+32)*2*CLK_DIV + CLK_DIV cycles.
REQ-028 An internal bit counter (7 bits) and phase counter SHALL reset to 0 at each frame start. There SHALL be no wrap within a frame.
REQ-029 If i_req_valid is held continuously, the next frame SHALL be accepted on the first IDLE cycle, giving back-to-back frames separated by exactly the GAP time.

Reset
REQ-030 While rst_n=0, including mid-frame, the block SHALL immediately force:
- state=IDLE
- o_spi_cs_n=1, o_spi_sclk=0, o_spi_mosi=0
- o_rsp_valid=0, o_rsp_rdata=0, o_busy=0
- o_req_ready=1
- all counters and shift registers to 0
REQ-031 After rst_n deasserts, no frame SHALL start until a new valid&&ready handshake.

Verification
REQ-032 CLK_DIV=2, write, cmd=7'h01, addr=32'h0000_1000, wdata=32'hDEAD_BEEF:
- MOSI bitstream is 0x81, 0x00001000, 0xDEADBEEF.
- cs_n is low for 290 cycles.
- o_rsp_valid pulses on the cycle cs_n rises.
- ready=1 four cycles later.
REQ-033 CLK_DIV=1, TURNAROUND=1, read addr=32'h10, bench slave drives MISO=32'hA5A5_0F0F after turnaround:
- o_rsp_rdata=32'hA5A50F0F with the pulse.
- cs_n is low for 147 cycles.
- MOSI=0 after the address bits.
REQ-034 Two writes with valid held high: the second frame's cs_n falls exactly 2*CLK_DIV*GAP_PERIODS+1 cycles after the first frame's cs_n rises. A change to i_req_wdata mid-frame does not alter the MOSI stream.
REQ-035 rst_n pulsed low at bit 20 of a read: cs_n=1, sclk=0 asynchronously, with no o_rsp_valid. A subsequent read completes correctly.
REQ-036 A read followed by a write: o_rsp_rdata keeps the read value after the write's o_rsp_valid pulse. o_busy stays high from acceptance until the end of GAP.

Source files
------------

// File: rtl/spi_bus_master.sv
// SPI mode-0 frame master: command/address/data frames with optional turnaround
// and read-back, bit period of 2*CLK_DIV block clocks, guaranteed CS-high gap.
module spi_bus_master #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned CLK_DIV     = 2,
    parameter int unsigned TURNAROUND  = 1,
    parameter int unsigned GAP_PERIODS = 1
) (
    input  logic                  i_spi_clk,
    input  logic                  rst_n,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_write,
    input  logic [6:0]            i_req_cmd,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic [DATA_WIDTH-1:0] i_req_wdata,
    output logic                  o_rsp_valid,
    output logic [DATA_WIDTH-1:0] o_rsp_rdata,
    output logic                  o_busy,
    output logic                  o_spi_sclk,
    output logic                  o_spi_cs_n,
    output logic                  o_spi_mosi,
    input  logic                  i_spi_miso
);

    localparam int unsigned TX_W    = 8 + ADDR_WIDTH + DATA_WIDTH;
    localparam int unsigned PERIOD  = 2 * CLK_DIV;
    localparam int unsigned GAP_CYC = PERIOD * GAP_PERIODS;
    localparam int unsigned PH_W    = $clog2(GAP_CYC + 1);

    // Bit counter runs across the whole frame; each state ends at a fixed bit index.
    localparam logic [6:0] CA_END = 7'(8 + ADDR_WIDTH - 1);
    localparam logic [6:0] WD_END = 7'(8 + ADDR_WIDTH + DATA_WIDTH - 1);
    localparam logic [6:0] TA_END = 7'(8 + ADDR_WIDTH + TURNAROUND - 1);
    localparam logic [6:0] RD_END = 7'(8 + ADDR_WIDTH + TURNAROUND + DATA_WIDTH - 1);

    localparam logic [PH_W-1:0] PH_LAST   = PH_W'(PERIOD - 1);
    localparam logic [PH_W-1:0] PH_HIGH   = PH_W'(CLK_DIV);
    localparam logic [PH_W-1:0] HOLD_LAST = PH_W'(CLK_DIV - 1);
    localparam logic [PH_W-1:0] GAP_LAST  = PH_W'(GAP_CYC - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD_ADDR,
        ST_WDATA,
        ST_TURNAROUND,
        ST_RDATA,
        ST_HOLD,
        ST_GAP
    } state_t;

    state_t                state_q, state_d;
    logic [PH_W-1:0]       phase_q, phase_d;
    logic [6:0]            bit_q, bit_d;
    logic [TX_W-1:0]       tx_q, tx_d;
    logic [DATA_WIDTH-1:0] rx_q, rx_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  write_q, write_d;
    logic                  rsp_valid_q, rsp_valid_d;

    logic shifting;
    logic period_end;

    assign shifting   = (state_q == ST_CMD_ADDR) || (state_q == ST_WDATA) ||
                        (state_q == ST_TURNAROUND) || (state_q == ST_RDATA);
    assign period_end = (phase_q == PH_LAST);

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        bit_d       = bit_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        rdata_d     = rdata_q;
        write_d     = write_q;
        rsp_valid_d = 1'b0;

        if (shifting) begin
            phase_d = period_end ? '0 : phase_q + 1'b1;
            if (period_end) begin
                bit_d = bit_q + 7'd1;
                tx_d  = {tx_q[TX_W-2:0], 1'b0};
            end
        end

        unique case (state_q)
            ST_IDLE: begin
                if (i_req_valid) begin
                    state_d = ST_CMD_ADDR;
                    phase_d = '0;
                    bit_d   = '0;
                    tx_d    = {i_req_write, i_req_cmd, i_req_addr, i_req_wdata};
                    rx_d    = '0;
                    write_d = i_req_write;
                end
            end
            ST_CMD_ADDR: begin
                if (period_end && bit_q == CA_END) begin
                    if (write_q)              state_d = ST_WDATA;
                    else if (TURNAROUND == 0) state_d = ST_RDATA;
                    else                      state_d = ST_TURNAROUND;
                end
            end
            ST_WDATA: begin
                if (period_end && bit_q == WD_END) state_d = ST_HOLD;
            end
            ST_TURNAROUND: begin
                if (period_end && bit_q == TA_END) state_d = ST_RDATA;
            end
            ST_RDATA: begin
                // Sample on the last high-phase cycle, i.e. at the SCLK falling edge.
                if (period_end) begin
                    rx_d = {rx_q[DATA_WIDTH-2:0], i_spi_miso};
                    if (bit_q == RD_END) state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                phase_d = phase_q + 1'b1;
                if (phase_q == HOLD_LAST) begin
                    state_d     = ST_GAP;
                    phase_d     = '0;
                    rsp_valid_d = 1'b1;
                    if (!write_q) rdata_d = rx_q;
                end
            end
            ST_GAP: begin
                phase_d = phase_q + 1'b1;
                if (phase_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                    phase_d = '0;
                    bit_d   = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_spi_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            phase_q     <= '0;
            bit_q       <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
            rdata_q     <= '0;
            write_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            bit_q       <= bit_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            rdata_q     <= rdata_d;
            write_q     <= write_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign o_req_ready = (state_q == ST_IDLE);
    assign o_busy      = (state_q != ST_IDLE);
    assign o_spi_cs_n  = (state_q == ST_IDLE) || (state_q == ST_GAP);
    assign o_spi_sclk  = shifting && (phase_q >= PH_HIGH);
    assign o_spi_mosi  = ((state_q == ST_CMD_ADDR) || (state_q == ST_WDATA)) && tx_q[TX_W-1];
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_rdata = rdata_q;

endmodule

// File: tb/tb_spi_bus_master.sv
// Bench for spi_bus_master: two instances (CLK_DIV=2 and CLK_DIV=1), an SPI slave
// model per instance and a frame scoreboard checked at each o_rsp_valid pulse.
module tb_spi_bus_master;

    typedef struct {
        int          id;
        int          nb;
        logic [79:0] bits;
        int          len;
        int          gap;
        logic [31:0] rdata;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    logic        a_valid, a_ready, a_write, a_rv, a_busy, a_sclk, a_cs_n, a_mosi, a_miso;
    logic [6:0]  a_cmd;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic        b_valid, b_ready, b_write, b_rv, b_busy, b_sclk, b_cs_n, b_mosi, b_miso;
    logic [6:0]  b_cmd;
    logic [31:0] b_addr, b_wdata, b_rdata;

    spi_bus_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .CLK_DIV(2), .TURNAROUND(1), .GAP_PERIODS(1)) dut_a (
        .i_spi_clk(clk), .rst_n(rst_n), .i_req_valid(a_valid), .o_req_ready(a_ready),
        .i_req_write(a_write), .i_req_cmd(a_cmd), .i_req_addr(a_addr), .i_req_wdata(a_wdata),
        .o_rsp_valid(a_rv), .o_rsp_rdata(a_rdata), .o_busy(a_busy), .o_spi_sclk(a_sclk),
        .o_spi_cs_n(a_cs_n), .o_spi_mosi(a_mosi), .i_spi_miso(a_miso)
    );

    spi_bus_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .CLK_DIV(1), .TURNAROUND(1), .GAP_PERIODS(1)) dut_b (
        .i_spi_clk(clk), .rst_n(rst_n), .i_req_valid(b_valid), .o_req_ready(b_ready),
        .i_req_write(b_write), .i_req_cmd(b_cmd), .i_req_addr(b_addr), .i_req_wdata(b_wdata),
        .o_rsp_valid(b_rv), .o_rsp_rdata(b_rdata), .o_busy(b_busy), .o_spi_sclk(b_sclk),
        .o_spi_cs_n(b_cs_n), .o_spi_mosi(b_mosi), .i_spi_miso(b_miso)
    );

    exp_t        sb[$];
    int          m_len[2], m_nb[2], m_rise[2], m_gap[2];
    logic [79:0] m_bits[2];
    logic        m_cs_p[2], m_sclk_p[2];
    logic [31:0] slave_word[2], last_rd[2];

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic get_ready(input int id); return id == 0 ? a_ready : b_ready; endfunction
    function automatic logic get_busy(input int id);  return id == 0 ? a_busy  : b_busy;  endfunction
    function automatic logic get_cs(input int id);    return id == 0 ? a_cs_n  : b_cs_n;  endfunction
    function automatic logic get_sclk(input int id);  return id == 0 ? a_sclk  : b_sclk;  endfunction
    function automatic logic get_mosi(input int id);  return id == 0 ? a_mosi  : b_mosi;  endfunction

    task automatic set_miso(input int id, input logic v);
        if (id == 0) a_miso = v; else b_miso = v;
    endtask

    task automatic drive(input int id, input logic v, input logic w, input logic [6:0] c,
                         input logic [31:0] ad, input logic [31:0] wd);
        if (id == 0) begin a_valid = v; a_write = w; a_cmd = c; a_addr = ad; a_wdata = wd; end
        else         begin b_valid = v; b_write = w; b_cmd = c; b_addr = ad; b_wdata = wd; end
    endtask

    // Slave presents read data for SCLK periods 41..72 (after 40 cmd/addr bits + 1 turnaround).
    function automatic logic slave_bit(input int id, input int p);
        logic [31:0] w;
        w = slave_word[id];
        if (p >= 41 && p < 73) return w[31 - (p - 41)];
        return 1'b0;
    endfunction

    function automatic exp_t mk(input int id, input logic w, input logic [6:0] c, input logic [31:0] ad,
                                input logic [31:0] wd, input int cdiv, input int gap, input logic [31:0] rd);
        exp_t e;
        logic [79:0] t;
        e.id = id; e.gap = gap; e.rdata = rd;
        if (w) begin
            e.nb = 72; e.bits = 80'({1'b1, c, ad, wd}); e.len = 72 * 2 * cdiv + cdiv;
        end else begin
            t = 80'({1'b0, c, ad});
            e.nb = 73; e.bits = t << 33; e.len = 73 * 2 * cdiv + cdiv;
        end
        return e;
    endfunction

    task automatic mon(input int id, input logic cs_n, input logic sclk, input logic mosi,
                       input logic rv, input logic [31:0] rd);
        exp_t e;
        if (!rst_n) begin
            m_len[id] = 0; m_nb[id] = 0; m_bits[id] = '0;
            m_cs_p[id] = 1'b1; m_sclk_p[id] = 1'b0;
            set_miso(id, 1'b0);
            return;
        end
        if (m_cs_p[id] && !cs_n) begin
            m_gap[id] = cyc - m_rise[id];
            m_len[id] = 0; m_nb[id] = 0; m_bits[id] = '0;
            set_miso(id, 1'b0);
        end
        if (!cs_n) begin
            m_len[id]++;
            if (sclk && !m_sclk_p[id]) begin
                m_bits[id] = {m_bits[id][78:0], mosi};
                m_nb[id]++;
            end
            if (!sclk && m_sclk_p[id]) set_miso(id, slave_bit(id, m_nb[id]));
        end
        if (rv) begin
            chk("rsp_valid_at_cs_rise", {cs_n, m_cs_p[id]}, 2'b10);
            chk("rsp_expected", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("frame_dut", id, e.id);
                chk("mosi_bit_count", m_nb[id], e.nb);
                chk("mosi_bits", m_bits[id], e.bits);
                chk("cs_low_cycles", m_len[id], e.len);
                chk("rsp_rdata", rd, e.rdata);
                if (e.gap != 0) chk("gap_to_next_cs_fall", m_gap[id], e.gap);
            end
        end
        if (!m_cs_p[id] && cs_n) m_rise[id] = cyc;
        m_cs_p[id] = cs_n;
        m_sclk_p[id] = sclk;
    endtask

    always @(negedge clk) begin
        mon(0, a_cs_n, a_sclk, a_mosi, a_rv, a_rdata);
        mon(1, b_cs_n, b_sclk, b_mosi, b_rv, b_rdata);
    end

    task automatic start(input int id, input logic w, input logic [6:0] c, input logic [31:0] ad,
                         input logic [31:0] wd, input logic hold);
        @(negedge clk);
        drive(id, 1'b1, w, c, ad, wd);
        for (int i = 0; i < 1000 && !get_ready(id); i++) @(negedge clk);
        chk("accept_ready", get_ready(id), 1'b1);
        @(posedge clk);
        #1;
        chk("frame_start_cs_sclk_mosi_busy", {get_cs(id), get_sclk(id), get_mosi(id), get_busy(id)},
            {1'b0, 1'b0, w, 1'b1});
        @(negedge clk);
        if (!hold) drive(id, 1'b0, ~w, ~c, ~ad, ~wd);
    endtask

    task automatic wait_done(input int id, input int exp_busy);
        int n;
        n = 0;
        while (get_busy(id) && n < 5000) begin
            n++;
            @(negedge clk);
        end
        chk("busy_cycles", n, exp_busy);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 1'b0, 1'b0, '0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0, '0);
        a_miso = 1'b0; b_miso = 1'b0;
        slave_word[0] = '0; slave_word[1] = '0;
        last_rd[0] = '0; last_rd[1] = '0;
        m_rise[0] = 0; m_rise[1] = 0; m_gap[0] = 0; m_gap[1] = 0;

        repeat (3) @(negedge clk);
        chk("reset_a_outputs", {a_ready, a_busy, a_cs_n, a_sclk, a_mosi, a_rv, a_rdata},
            {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0});
        chk("reset_b_outputs", {b_ready, b_busy, b_cs_n, b_sclk}, 4'b1010);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("idle_after_reset", {a_cs_n, a_busy, b_cs_n, b_busy}, 4'b1010);

        // Write on CLK_DIV=2: 0x81, 0x00001000, 0xDEADBEEF; 290 cycles cs low, 4 gap cycles.
        sb.push_back(mk(0, 1'b1, 7'h01, 32'h0000_1000, 32'hDEAD_BEEF, 2, 0, last_rd[0]));
        start(0, 1'b1, 7'h01, 32'h0000_1000, 32'hDEAD_BEEF, 1'b0);
        wait_done(0, 294);

        // Read on CLK_DIV=1 with slave data.
        slave_word[1] = 32'hA5A5_0F0F;
        last_rd[1] = 32'hA5A5_0F0F;
        sb.push_back(mk(1, 1'b0, 7'h03, 32'h0000_0010, 32'h0, 1, 0, last_rd[1]));
        start(1, 1'b0, 7'h03, 32'h0000_0010, 32'h0, 1'b0);
        wait_done(1, 149);

        // Back-to-back writes with valid held; inputs change to frame 2 mid frame 1.
        sb.push_back(mk(0, 1'b1, 7'h02, 32'h0000_2000, 32'h1234_5678, 2, 0, last_rd[0]));
        start(0, 1'b1, 7'h02, 32'h0000_2000, 32'h1234_5678, 1'b1);
        drive(0, 1'b1, 1'b1, 7'h03, 32'h0000_3000, 32'hCAFE_F00D);
        sb.push_back(mk(0, 1'b1, 7'h03, 32'h0000_3000, 32'hCAFE_F00D, 2, 5, last_rd[0]));
        for (int i = 0; i < 2000 && !a_ready; i++) @(negedge clk);
        chk("b2b_ready", a_ready, 1'b1);
        @(posedge clk);
        #1;
        chk("b2b_second_cs_fall", a_cs_n, 1'b0);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 7'h7F, 32'hFFFF_FFFF, 32'h0);
        wait_done(0, 294);

        // Reset around bit 20 of a read: outputs forced without a clock edge.
        slave_word[0] = 32'h3C3C_5AA5;
        start(0, 1'b0, 7'h04, 32'h0000_0044, 32'h0, 1'b0);
        repeat (80) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async_reset_a", {a_cs_n, a_sclk, a_mosi, a_rv, a_busy, a_ready}, 6'b100001);
        chk("async_reset_b_rdata", b_rdata, 32'h0);
        last_rd[1] = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("no_frame_after_reset", {a_cs_n, a_busy, a_rv}, 3'b100);

        // Read then write: rdata must survive the write's response.
        last_rd[0] = 32'h3C3C_5AA5;
        sb.push_back(mk(0, 1'b0, 7'h06, 32'h0000_0080, 32'h0, 2, 0, last_rd[0]));
        start(0, 1'b0, 7'h06, 32'h0000_0080, 32'h0, 1'b0);
        wait_done(0, 298);
        sb.push_back(mk(0, 1'b1, 7'h07, 32'h0000_0090, 32'h0BAD_F00D, 2, 0, last_rd[0]));
        start(0, 1'b1, 7'h07, 32'h0000_0090, 32'h0BAD_F00D, 1'b0);
        wait_done(0, 294);
        chk("rdata_kept_after_write", a_rdata, 32'h3C3C_5AA5);

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
